// File: rtl/audio_pkg.sv
// Shared audio definitions: frame geometry and the padded stereo sample used by the I2S path
// and the audio mixer.
package audio_pkg;

  localparam int unsigned FRAME_CLKS = 256;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned SLOTS      = 64;

  // Both channels left-justified in 32-bit slots; left occupies the upper half.
  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one stereo sample per 256-clk frame, MSB first with a one-slot delay,
// silence plus an underrun pulse when no sample is held at the frame boundary.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    audio_sclk,
  output logic                    audio_lrck,
  output logic                    audio_dac,
  output logic                    underrun
);

  localparam int unsigned CntW    = $clog2(FRAME_CLKS);
  localparam int unsigned SlotW   = $clog2(SLOTS);
  localparam int unsigned PadBits = SLOT_BITS - SAMPLE_WIDTH;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SlotW-1:0] slot, slot_next;
  stereo_sample_t   frame_q, frame_d, pend_q, pend_d, pend_in;
  logic [2*SLOT_BITS-1:0] frame_bits;
  logic pend_valid_q, pend_valid_d;
  logic lrck_q, lrck_d, dac_q, dac_d, underrun_q, underrun_d;
  logic accept, frame_end, bit_edge;

  assign slot       = cnt_q[CntW-1:2];
  assign slot_next  = slot + 1'b1;
  assign frame_bits = frame_q;
  assign accept     = sample_valid & ~pend_valid_q;
  assign frame_end  = (cnt_q == CntW'(FRAME_CLKS - 1));
  assign bit_edge   = (cnt_q[1:0] == 2'b11);

  // Sign bit lands in slot bit 31; everything below the sample is zero.
  assign pend_in.left  = SLOT_BITS'(sample_left) << PadBits;
  assign pend_in.right = SLOT_BITS'(sample_right) << PadBits;

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    frame_d      = frame_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    lrck_d       = lrck_q;
    dac_d        = dac_q;
    underrun_d   = 1'b0;

    // On the sclk falling edge, present the bit for the next slot. ~slot == 63 - slot, so the
    // bit driven into slot s+1 is frame bit s counted from the MSB.
    if (bit_edge) begin
      lrck_d = slot_next[SlotW-1];
      dac_d  = frame_bits[~slot];
    end

    if (accept) begin
      pend_d       = pend_in;
      pend_valid_d = 1'b1;
    end

    // Accept can only coincide with a load when pend is empty, so it survives the else branch.
    if (frame_end) begin
      if (pend_valid_q) begin
        frame_d      = pend_q;
        pend_valid_d = 1'b0;
      end else begin
        frame_d    = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      frame_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      lrck_q       <= 1'b0;
      dac_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      lrck_q       <= lrck_d;
      dac_q        <= dac_d;
      underrun_q   <= underrun_d;
    end
  end

  assign sample_ready = ~pend_valid_q;
  assign audio_sclk   = cnt_q[1];
  assign audio_lrck   = lrck_q;
  assign audio_dac    = dac_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomized bench for audio_i2s_tx at 16- and 24-bit sample widths, checked every clk against
// a frame-level model of what each I2S slot must carry.
module tb_audio_i2s_tx;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        in_v[2];
  logic [31:0] in_l[2], in_r[2];
  logic        o_rdy[2], o_sclk[2], o_lrck[2], o_dac[2], o_und[2];

  audio_i2s_tx #(.SAMPLE_WIDTH(16)) dut16 (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(in_v[0]),
    .sample_ready(o_rdy[0]),
    .sample_left (in_l[0][15:0]),
    .sample_right(in_r[0][15:0]),
    .audio_sclk  (o_sclk[0]),
    .audio_lrck  (o_lrck[0]),
    .audio_dac   (o_dac[0]),
    .underrun    (o_und[0])
  );

  audio_i2s_tx #(.SAMPLE_WIDTH(24)) dut24 (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(in_v[1]),
    .sample_ready(o_rdy[1]),
    .sample_left (in_l[1][23:0]),
    .sample_right(in_r[1][23:0]),
    .audio_sclk  (o_sclk[1]),
    .audio_lrck  (o_lrck[1]),
    .audio_dac   (o_dac[1]),
    .underrun    (o_und[1])
  );

  int checks = 0;
  int errors = 0;

  // Model: current counter, holding register and the frame now on the wire, per instance.
  int          m_cnt;
  bit          m_pv[2], m_under[2], off[2];
  logic [31:0] m_pl[2], m_pr[2], m_fl[2], m_fr[2], m_prev_r[2];
  int          width[2] = '{16, 24};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cnt %0d, t=%0t)", tag, got, exp, m_cnt, $time);
    end
  endtask

  function automatic logic [31:0] pad(input logic [31:0] x, input int w);
    return x << (32 - w);
  endfunction

  // Slot 0 still carries the previous right LSB; slots 1..32 left MSB..LSB, 33..63 right MSB..
  function automatic logic exp_dac(input int i);
    int s = m_cnt / 4;
    if (s == 0) return m_prev_r[i][0];
    if (s <= 32) return m_fl[i][32 - s];
    return m_fr[i][64 - s];
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      m_pv[i] = 0; m_under[i] = 0;
      m_pl[i] = '0; m_pr[i] = '0; m_fl[i] = '0; m_fr[i] = '0; m_prev_r[i] = '0;
    end
  endtask

  task automatic do_checks();
    for (int i = 0; i < 2; i++) begin
      string n = (i == 0) ? "w16" : "w24";
      check_eq({n, " sclk"}, 32'(o_sclk[i]), 32'((m_cnt % 4) >= 2));
      check_eq({n, " lrck"}, 32'(o_lrck[i]), 32'((m_cnt / 4) >= 32));
      check_eq({n, " dac"}, 32'(o_dac[i]), 32'(exp_dac(i)));
      check_eq({n, " underrun"}, 32'(o_und[i]), 32'(m_under[i]));
      check_eq({n, " ready"}, 32'(o_rdy[i]), 32'(!m_pv[i]));
    end
  endtask

  // Advance the model over one posedge with the inputs now applied, then check at the negedge.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      bit acc = in_v[i] && !m_pv[i];
      m_under[i] = 0;
      if (m_cnt == 255) begin
        m_prev_r[i] = m_fr[i];
        if (m_pv[i]) begin
          m_fl[i] = m_pl[i]; m_fr[i] = m_pr[i]; m_pv[i] = 0;
        end else begin
          m_fl[i] = '0; m_fr[i] = '0; m_under[i] = 1;
        end
      end
      if (acc) begin
        m_pl[i] = pad(in_l[i], width[i]);
        m_pr[i] = pad(in_r[i], width[i]);
        m_pv[i] = 1;
        off[i]  = 0;
      end
    end
    m_cnt = (m_cnt + 1) % 256;
    @(negedge clk);
    for (int i = 0; i < 2; i++) in_v[i] = off[i];
    do_checks();
  endtask

  // pct: chance per idle cycle of starting a new offer; an offer is held until accepted.
  task automatic run(input int n, input int pct);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!off[i] && pct > 0 && $urandom_range(0, 99) < pct) begin
          off[i]  = 1;
          in_l[i] = 32'($urandom) >> (32 - width[i]);
          in_r[i] = 32'($urandom) >> (32 - width[i]);
        end
        in_v[i] = off[i];
      end
      tick();
    end
  endtask

  task automatic run_until(input int target, input int pct);
    for (int k = 0; k < 600 && m_cnt != target; k++) run(1, pct);
    check_eq("align cnt", 32'(m_cnt), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_v[i] = 0; in_l[i] = '0; in_r[i] = '0; off[i] = 0;
    end
    reset_n = 1'b1;
    model_reset();
    #2 reset_n = 1'b0;
    #10 do_checks();
    @(negedge clk);
    reset_n = 1'b1;

    // Free run with no samples: silence, lrck/sclk cadence, one underrun per frame.
    run(600, 0);

    // Directed sample accepted at cnt 10 (16-bit pattern; 24-bit gets ABCDEF on the left).
    run_until(10, 0);
    off[0] = 1; in_l[0] = 32'h8001;   in_r[0] = 32'h7FFE;
    off[1] = 1; in_l[1] = 32'hABCDEF; in_r[1] = 32'h123456;
    run(1, 0);
    run(600, 0);

    // Back-to-back offers: every frame filled, no underrun.
    run(1024, 100);

    // Offer only at the cnt==255 edge with pend empty: that frame is silent, next one plays.
    run(520, 0);
    run_until(255, 0);
    off[0] = 1; in_l[0] = 32'h5A5A; in_r[0] = 32'hA5A5;
    off[1] = 1; in_l[1] = 32'h800001; in_r[1] = 32'h7FFFFE;
    run(1, 0);
    run(600, 0);

    // Sparse random traffic.
    run(2048, 1);

    // Reset at slot 20 with a frame in flight and a sample pending.
    run(300, 100);
    run_until(80, 100);
    #2 reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_v[i] = 0; off[i] = 0;
    end
    model_reset();
    #1 do_checks();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      do_checks();
    end
    reset_n = 1'b1;
    run(600, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
